board_win_checker: RTL and testbench
====================================

// Module: board_win_checker
// PURPOSE
//  Reader counterpart to the board generator: scans the SIZE x SIZE colour board in raster order
//  through a 1-cycle-latency read port and compares every cell with cell (0,0).
//  Reports the match count and WIN (whole board one colour) to the game controller after each move.
// PARAMETERS
//  MAX_SIZE  26  largest legal board edge; SIZE above this is clamped to MAX_SIZE
//  COLOR_W   3   bits per cell colour
//  CNT_W     10  width of MATCH_COUNT (must hold MAX_SIZE*MAX_SIZE = 676)
// PORTS
//  CLOCK        in   1        system clock, all logic on posedge
//  RESET        in   1        synchronous, active-high reset
//  START        in   1        begin a scan; sampled only in IDLE
//  SIZE         in   5        board edge length, latched on accepted START
//  RD_EN        out  1        read strobe to board storage
//  RD_ROW       out  5        read row address, valid when RD_EN=1
//  RD_COL       out  5        read column address, valid when RD_EN=1
//  RD_DATA      in   COLOR_W  cell colour; valid the cycle after the RD_EN that requested it
//  BUSY         out  1        high from the cycle after accepted START until DONE
//  DONE         out  1        one-cycle pulse: result valid
//  WIN          out  1        1 = every scanned cell equals REF_COLOR; held until next accepted START
//  MATCH_COUNT  out  CNT_W    cells equal to REF_COLOR, (0,0) included; held like WIN
//  REF_COLOR    out  COLOR_W  colour of cell (0,0) from the last scan
// BEHAVIOUR
//  Reset: state IDLE; RD_EN, BUSY, DONE, WIN = 0; MATCH_COUNT, REF_COLOR, RD_ROW, RD_COL = 0.
//  RESET asserted in any state (mid-scan included) aborts immediately; RESET beats START in the same cycle.
//  States: IDLE -> SCAN -> DRAIN -> FIN -> IDLE.
//  IDLE: START=1 latches S = min(SIZE, MAX_SIZE) and clears WIN, MATCH_COUNT; BUSY=1 next cycle.
//    S=0: go directly to FIN (no reads); DONE pulses 1 cycle after START, WIN=0, MATCH_COUNT=0.
//  SCAN: one read per cycle, RD_EN=1, addresses in raster order (0,0),(0,1)..(0,S-1),(1,0)..(S-1,S-1).
//    COL wraps to 0 and ROW increments when COL+1 == S. After the read of (S-1,S-1) is issued, go to DRAIN.
//  Compare pipeline: a 1-cycle-delayed copy of RD_EN tags returning data.
//    First returned word (cell 0) loads REF_COLOR and sets count = 1.
//    Each later word increments count if RD_DATA == REF_COLOR (full COLOR_W compare, no masking).
//  DRAIN: RD_EN=0; absorb last returned word. FIN: DONE=1 for one cycle; WIN = (count == S*S); BUSY=0.
//  Timing with START accepted at cycle 0, N = S*S cells:
//    reads issued cycles 1..N; data at 2..N+1; DONE at cycle N+2.
//  START while BUSY, or in the DONE cycle, is ignored (not queued).
//  SIZE changes after START have no effect on the running scan.
//  Count never saturates: N <= 676 always fits in CNT_W.
//  RD_DATA is ignored on cycles with no outstanding read.
// TESTING
//  3x3, all cells colour 2, START @0 -> reads (0,0)..(2,2) cycles 1-9; DONE @11; WIN=1, MATCH_COUNT=9, REF_COLOR=2.
//  3x3 colour 5, cell (2,1)=3 -> DONE @11, WIN=0, MATCH_COUNT=8, REF_COLOR=5.
//  SIZE=1, cell colour 7 -> one read @1, DONE @3, WIN=1, MATCH_COUNT=1.
//  SIZE=0 -> no RD_EN ever; DONE @1, WIN=0, MATCH_COUNT=0. SIZE=31 -> scans 26x26: 676 reads, DONE @678.
//  26x26 checkerboard 0/1 -> row-wrap addresses exact; MATCH_COUNT=338, WIN=0.
//  5x5 scan: RESET @10 -> next cycle IDLE, RD_EN=0, BUSY=0, outputs 0.
//    START @12 with SIZE=2 -> DONE @18.
//    START pulse @5 during busy 4x4 scan -> ignored, single DONE @18.

Source files
------------

// File: rtl/board_win_checker.sv
// board_win_checker: scans a SIZE x SIZE colour board in raster order and reports the match count and WIN.
// Latency: N = S*S reads in cycles 1..N after START; DONE pulses in cycle N+2 (S=0: cycle 1).
// Backpressure: none; START is accepted only in IDLE, and a START while busy or in the DONE cycle is dropped.
// Ports:
//   clock, reset (sync, active-high), start, size     - control inputs
//   rd_en, rd_row, rd_col / rd_data                   - 1-cycle-latency board read port
//   busy, done, win, match_count, ref_color           - status and result, held until next START
module board_win_checker #(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3,
  parameter int CNT_W    = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         size,
  output logic               rd_en,
  output logic [4:0]         rd_row,
  output logic [4:0]         rd_col,
  input  logic [COLOR_W-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic [CNT_W-1:0]   match_count,
  output logic [COLOR_W-1:0] ref_color
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  state_t             state;
  logic [4:0]         edge_len;    // latched board edge, immune to later size changes
  logic [CNT_W-1:0]   n_cells;     // edge_len squared
  logic               rd_vld;      // rd_en delayed one cycle: rd_data carries a requested cell
  logic               first;       // next returned word is cell (0,0)

  logic [4:0]         size_clamped;
  logic [CNT_W-1:0]   size_sq;
  logic [CNT_W-1:0]   count_next;
  logic               last_addr;
  logic               last_col;

  always_comb begin
    size_clamped = (size > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : size;
    size_sq      = CNT_W'(size_clamped) * CNT_W'(size_clamped);
    last_col     = (rd_col == edge_len - 5'd1);
    last_addr    = last_col && (rd_row == edge_len - 5'd1);
    // Count including the word arriving this cycle; cell (0,0) always matches itself.
    count_next   = match_count;
    if (rd_vld) begin
      if (first) count_next = CNT_W'(1);
      else       count_next = match_count + CNT_W'(rd_data == ref_color);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      edge_len    <= '0;
      n_cells     <= '0;
      rd_vld      <= 1'b0;
      first       <= 1'b0;
      rd_en       <= 1'b0;
      rd_row      <= '0;
      rd_col      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      win         <= 1'b0;
      match_count <= '0;
      ref_color   <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_vld) begin
        match_count <= count_next;
        first       <= 1'b0;
        if (first) ref_color <= rd_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            edge_len    <= size_clamped;
            n_cells     <= size_sq;
            win         <= 1'b0;
            match_count <= '0;
            first       <= 1'b1;
            rd_row      <= '0;
            rd_col      <= '0;
            if (size_clamped == 5'd0) begin
              // Empty board: nothing to read, report immediately.
              done  <= 1'b1;
              state <= FIN;
            end else begin
              rd_en <= 1'b1;
              busy  <= 1'b1;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (last_addr) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else if (last_col) begin
            rd_col <= '0;
            rd_row <= rd_row + 5'd1;
          end else begin
            rd_col <= rd_col + 5'd1;
          end
        end
        DRAIN: begin
          // The last cell arrives this cycle, so judge WIN on the updated count.
          win   <= (count_next == n_cells);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= FIN;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_win_checker.sv
// tb_board_win_checker: directed scans against a behavioural board memory with hand-computed results.
// Latency: checks DONE cycle, read order/timing, WIN, MATCH_COUNT and REF_COLOR per scan.
// Backpressure: n/a; also exercises reset abort, START during busy, and SIZE clamping.
module tb_board_win_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] size;
  logic       rd_en;
  logic [4:0] rd_row;
  logic [4:0] rd_col;
  logic [2:0] rd_data;
  logic       busy;
  logic       done;
  logic       win;
  logic [9:0] match_count;
  logic [2:0] ref_color;

  logic [2:0] board [0:25][0:25];

  int n_checks = 0;
  int n_errors = 0;

  board_win_checker #(.MAX_SIZE(26), .COLOR_W(3), .CNT_W(10)) dut (
    .clock(clock), .reset(reset), .start(start), .size(size),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .busy(busy), .done(done), .win(win), .match_count(match_count), .ref_color(ref_color)
  );

  always #5 clock = ~clock;

  // Board storage: 1-cycle read latency, garbage on cycles without a read.
  always @(posedge clock) begin
    if (rd_en) rd_data <= board[rd_row][rd_col];
    else       rd_data <= 3'($urandom);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_const(input int c);
    for (int r = 0; r < 26; r++)
      for (int k = 0; k < 26; k++)
        board[r][k] = 3'(c);
  endtask

  task automatic fill_checker();
    for (int r = 0; r < 26; r++)
      for (int k = 0; k < 26; k++)
        board[r][k] = 3'((r + k) % 2);
  endtask

  // Issues START in the current cycle (cycle 0) and follows the scan cycle by cycle.
  task automatic run_scan(input string name, input int sz, input int exp_done,
                          input int exp_win, input int exp_cnt, input int exp_ref,
                          input int glitch);
    int edge_len, exp_n, rel, got_done, nrd, er, ec, aerr, berr, extra;
    edge_len = (sz > 26) ? 26 : sz;
    exp_n = edge_len * edge_len;
    @(negedge clock);
    start = 1'b1;
    size  = 5'(sz);
    @(negedge clock);
    rel = 1; got_done = -1; nrd = 0; er = 0; ec = 0; aerr = 0; berr = 0; extra = 0;
    while (rel < exp_done + 20) begin
      start = 1'b0;
      if (done) begin
        got_done = rel;
        break;
      end
      if (rd_en) begin
        if (int'(rd_row) != er || int'(rd_col) != ec || rel != nrd + 1) aerr++;
        nrd++;
        ec++;
        if (ec == edge_len) begin
          ec = 0;
          er++;
        end
      end
      if (!busy) berr++;
      start = (rel == glitch);
      size  = 5'($urandom);
      @(negedge clock);
      rel++;
    end
    start = 1'b0;
    chk({name, " done_cycle"}, got_done, exp_done);
    chk({name, " reads"}, nrd, exp_n);
    chk({name, " addr_order"}, aerr, 0);
    chk({name, " busy_during"}, berr, 0);
    chk({name, " win"}, int'(win), exp_win);
    chk({name, " match_count"}, int'(match_count), exp_cnt);
    chk({name, " ref_color"}, int'(ref_color), exp_ref);
    chk({name, " busy_at_done"}, int'(busy), 0);
    @(negedge clock);
    chk({name, " done_pulse_width"}, int'(done), 0);
    repeat (20) begin
      if (done || rd_en) extra++;
      @(negedge clock);
    end
    chk({name, " quiet_after"}, extra, 0);
    chk({name, " win_held"}, int'(win), exp_win);
    chk({name, " count_held"}, int'(match_count), exp_cnt);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;   // reset must win over start
    size  = 5'd3;
    fill_const(2);
    repeat (3) @(negedge clock);
    chk("reset rd_en", int'(rd_en), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset win", int'(win), 0);
    chk("reset match_count", int'(match_count), 0);
    chk("reset ref_color", int'(ref_color), 0);
    chk("reset rd_row", int'(rd_row), 0);
    chk("reset rd_col", int'(rd_col), 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);

    fill_const(2);
    run_scan("3x3_all2", 3, 11, 1, 9, 2, -1);

    fill_const(5);
    board[2][1] = 3'd3;
    run_scan("3x3_one_off", 3, 11, 0, 8, 5, -1);

    fill_const(7);
    run_scan("1x1", 1, 3, 1, 1, 7, -1);

    run_scan("size0", 0, 1, 0, 0, 7, -1);

    fill_const(6);
    run_scan("size31_clamp", 31, 678, 1, 676, 6, -1);

    fill_checker();
    run_scan("26x26_checker", 26, 678, 0, 338, 0, -1);

    fill_const(3);
    board[0][0] = 3'd3;
    run_scan("4x4_start_glitch", 4, 18, 1, 16, 3, 5);

    // 5x5 scan aborted by reset in cycle 10, restarted at cycle 12 with a 2x2 board.
    fill_const(4);
    @(negedge clock);
    start = 1'b1;
    size  = 5'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("abort rd_en_before", int'(rd_en), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort rd_en", int'(rd_en), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort match_count", int'(match_count), 0);
    chk("abort ref_color", int'(ref_color), 0);
    fill_checker();
    run_scan("2x2_after_abort", 2, 6, 0, 2, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
